multiprecision_add_sub_sequencer: RTL
=====================================

Name: multiprecision_add_sub_sequencer

Overview:
Sequences one WORD_WIDTH-bit binary adder/subtractor over WORD_COUNT words to compute a full-width A+B+carry_in or A-B-carry_in, least-significant word first, one word per cycle. Internal carry (add) or borrow (sub) chains between words through a register. Ready/valid handshakes on input and output. Sits between a wide-operand producer and consumer where a full-width adder is too large or too slow.

Parameters:
WORD_WIDTH, 8, width of the shared adder/subtractor word; must be >= 1.
WORD_COUNT, 4, number of words per operand; must be >= 1. TOTAL_WIDTH = WORD_WIDTH*WORD_COUNT.

Ports:
clock  input  1  single clock; all state changes on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
input_valid  input  1  operand set is offered.
input_ready  output  1  block accepts an operand set this cycle.
add_sub  input  1  0 selects A+B+carry_in; 1 selects A-B-carry_in.
carry_in  input  1  carry (add) or borrow (sub) into word 0.
A_in  input  TOTAL_WIDTH  operand A.
B_in  input  TOTAL_WIDTH  operand B.
output_valid  output  1  result is offered.
output_ready  input  1  consumer takes the result this cycle.
sum_out  output  TOTAL_WIDTH  full-width result.
carry_out  output  1  carry (add) or borrow (sub) out of the top word.
overflow_out  output  1  signed two's-complement overflow of the full-width result.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; output_valid=0; sum_out=0; carry_out=0; overflow_out=0; word index, carry register, and operand registers cleared. Inputs are ignored while reset_n is low.
- input_ready=1 exactly when state==IDLE. output_valid=1 exactly when state==DONE. Both are state decodes.
- IDLE: an accept occurs when input_valid=1. On that edge, latch A_in, B_in, add_sub, carry_in into the operand and carry registers, set index=0, and go to RUN.
- RUN: each cycle computes word[index] = A_word op B_word op carry_reg using WORD_WIDTH+1-bit arithmetic. The low WORD_WIDTH bits go to accumulator word[index]; the top bit goes to carry_reg.
  - For subtract, the top bit is the borrow (1 = borrow) and feeds the next word's subtract unchanged.
  - index increments. add_sub is held constant for the whole operation.
- RUN to DONE occurs on the edge that processes index WORD_COUNT-1. On that edge:
  - sum_out <= accumulator, including the final word.
  - carry_out <= final carry_reg.
  - overflow_out <= signed overflow from the MSBs of A, B, and sum:
    - add: sign(A)==sign(B) and sign(sum)!=sign(A).
    - sub: sign(A)!=sign(B) and sign(sum)!=sign(A).
- Latency: output_valid rises WORD_COUNT rising edges after the accept edge.
- DONE: sum_out, carry_out, and overflow_out hold stable while output_valid=1 and output_ready=0, for unbounded cycles. When output_ready=1, the handshake completes on that edge and the state goes to IDLE.
- No overlap between DONE and IDLE. Best-case period between accepts is WORD_COUNT+2 cycles.
- sum_out, carry_out, and overflow_out change only on the RUN-to-DONE edge or on reset. They retain the last result after the handshake until the next completion.
- The index counter never wraps inside RUN. It is reset to 0 on each accept.
- WORD_COUNT=1: RUN lasts one cycle; behaviour is otherwise identical.
- input_valid or new operand values during RUN or DONE have no effect. A_in and B_in are sampled only on the accept edge.
- Reset asserted mid-RUN or mid-DONE aborts the operation. Partial results and carry are discarded, with no output handshake. The next operation after reset must not see a stale carry.

Test Plan:
(Parameters WORD_WIDTH=8, WORD_COUNT=4 unless noted.)
1. Add with ripple carry: A=0x00FFFFFF, B=0x00000001, add, cin=0 -> sum_out=0x01000000, carry_out=0, overflow_out=0. output_valid rises exactly 4 edges after accept; input_ready=0 throughout RUN and DONE.
2. Subtract with borrow: A=0x00000000, B=0x00000001, sub, cin=0 -> sum_out=0xFFFFFFFF, carry_out=1, overflow_out=0. Same operands with cin=1 -> 0xFFFFFFFE, carry_out=1.
3. Carry-in and overflow:
   - A=0xFFFFFFFF, B=0, add, cin=1 -> sum_out=0x00000000, carry_out=1, overflow_out=0.
   - A=0x7FFFFFFF, B=1, add -> 0x80000000, carry_out=0, overflow_out=1.
   - A=0x80000000, B=1, sub -> 0x7FFFFFFF, overflow_out=1.
4. Backpressure: hold output_ready=0 for 10 cycles after output_valid -> sum_out, carry_out, and overflow_out stable; input_valid pulses with new operands are ignored. Raise output_ready -> one handshake, IDLE next cycle, input_ready=1.
5. Reset mid-operation: deassert reset_n during RUN index 2 of 0xFFFFFFFF+1 -> output_valid=0 and all outputs 0 immediately, with no result emitted. A following 0x00000001+0x00000001 add yields 0x00000002, carry_out=0.
6. Throughput and WORD_COUNT=1:
   - With input_valid and output_ready tied high, accepts occur every 6 cycles, and 3 results match the reference model.
   - Rerun test 1 with WORD_COUNT=1 (A=0xFF, B=0x01) -> sum_out=0x00, carry_out=1, output_valid 1 edge after accept.

Source files
------------

// File: rtl/multiprecision_add_sub_sequencer.sv
// Word-serial multiprecision adder/subtractor: one WORD_WIDTH slice per cycle, LSW first,
// carry/borrow chained through a register, ready/valid on both sides.
module multiprecision_add_sub_sequencer #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned WORD_COUNT = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               input_valid,
  output logic                               input_ready,
  input  logic                               add_sub,
  input  logic                               carry_in,
  input  logic [WORD_WIDTH*WORD_COUNT-1:0]   A_in,
  input  logic [WORD_WIDTH*WORD_COUNT-1:0]   B_in,
  output logic                               output_valid,
  input  logic                               output_ready,
  output logic [WORD_WIDTH*WORD_COUNT-1:0]   sum_out,
  output logic                               carry_out,
  output logic                               overflow_out
);

  localparam int unsigned TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT;
  localparam int unsigned WORD_W1     = WORD_WIDTH + 1;
  localparam int unsigned IDX_W       = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [TOTAL_WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic                   a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic                   sub_q, sub_d, carry_q, carry_d;
  logic                   cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH:0]    word_res;
  logic                   last_word;
  logic                   sum_msb;

  assign last_word = (idx_q == LAST_IDX);
  assign sum_msb   = word_res[WORD_WIDTH-1];

  // Operands shift right each RUN cycle so the active word is always the low slice.
  always_comb begin
    if (sub_q) begin
      word_res = {1'b0, a_q[WORD_WIDTH-1:0]} - {1'b0, b_q[WORD_WIDTH-1:0]} - WORD_W1'(carry_q);
    end else begin
      word_res = {1'b0, a_q[WORD_WIDTH-1:0]} + {1'b0, b_q[WORD_WIDTH-1:0]} + WORD_W1'(carry_q);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (input_valid) state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (output_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state and handshake decodes.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    sub_d        = sub_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    input_ready  = (state_q == IDLE);
    output_valid = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (input_valid) begin
          a_d     = A_in;
          b_d     = B_in;
          a_msb_d = A_in[TOTAL_WIDTH-1];
          b_msb_d = B_in[TOTAL_WIDTH-1];
          sub_d   = add_sub;
          carry_d = carry_in;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> WORD_WIDTH;
        b_d     = b_q >> WORD_WIDTH;
        acc_d   = (acc_q >> WORD_WIDTH)
                | (TOTAL_WIDTH'(word_res[WORD_WIDTH-1:0]) << (TOTAL_WIDTH - WORD_WIDTH));
        carry_d = word_res[WORD_WIDTH];
        if (last_word) begin
          sum_d  = acc_d;
          cout_d = word_res[WORD_WIDTH];
          if (sub_q) begin
            ovf_d = (a_msb_q != b_msb_q) && (sum_msb != a_msb_q);
          end else begin
            ovf_d = (a_msb_q == b_msb_q) && (sum_msb != a_msb_q);
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum_out      = sum_q;
  assign carry_out    = cout_q;
  assign overflow_out = ovf_q;

endmodule
